// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte stores to TXDATA are queued in a small FIFO
// and shifted out as 8N1 frames; STATUS and a 16-bit divisor are exposed for polling.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [7:0]  write_data,
    input  logic        write_enable,
    output logic [7:0]  read_data,
    output logic        tx,
    output logic        tx_idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Line level driven while the FSM sits in a given state.
    function automatic logic line_level(input logic [1:0] st, input logic bit0);
        logic lvl;
        case (st)
            ST_START: lvl = 1'b0;
            ST_DATA:  lvl = bit0;
            default:  lvl = 1'b1;
        endcase
        return lvl;
    endfunction

    logic             hit_s;
    logic [1:0]       off_s;
    logic             wr_tx_s, wr_status_s, wr_div_lo_s, wr_div_hi_s;
    logic [7:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic [4:0]       count_ext_s;
    logic [3:0]       level_s;
    logic             full_s, empty_s, push_s, pop_s, drop_s;
    logic [1:0]       state_r, state_nxt_s;
    logic [7:0]       shift_r, shift_nxt_s;
    logic [2:0]       bit_idx_r, bit_idx_nxt_s;
    logic [15:0]      baud_r, baud_nxt_s;
    logic [15:0]      div_r, div_act_r, div_act_nxt_s, div_eff_s;
    logic             bit_end_s;
    logic             overflow_r;
    logic             tx_r, tx_idle_r;
    logic [7:0]       status_s;

    assign hit_s       = (address[31:2] == BASE_ADDR[31:2]);
    assign off_s       = address[1:0];
    assign wr_tx_s     = write_enable && hit_s && (off_s == 2'd0);
    assign wr_status_s = write_enable && hit_s && (off_s == 2'd1);
    assign wr_div_lo_s = write_enable && hit_s && (off_s == 2'd2);
    assign wr_div_hi_s = write_enable && hit_s && (off_s == 2'd3);

    assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s   = (count_r == CNT_W'(0));
    // A pop in the same cycle frees the slot, so a push to a full FIFO survives.
    assign push_s    = wr_tx_s && (!full_s || pop_s);
    assign drop_s    = wr_tx_s && full_s && !pop_s;
    assign div_eff_s = (div_r == 16'd0) ? 16'd1 : div_r;
    assign bit_end_s = (baud_r == (div_act_r - 16'd1));

    assign count_ext_s = 5'(count_r);
    assign level_s     = (count_ext_s > 5'd15) ? 4'd15 : count_ext_s[3:0];
    assign status_s    = {level_s, overflow_r, empty_s, full_s, (state_r != ST_IDLE)};

    // Combinational load data for the register window.
    always_comb begin
        read_data = 8'h00;
        if (hit_s) begin
            case (off_s)
                2'd1:    read_data = status_s;
                2'd2:    read_data = div_r[7:0];
                2'd3:    read_data = div_r[15:8];
                default: read_data = 8'h00;
            endcase
        end else begin
            read_data = 8'h00;
        end
    end

    // Frame sequencer next-state logic, including FIFO pop and divisor latch.
    always_comb begin
        state_nxt_s   = state_r;
        shift_nxt_s   = shift_r;
        bit_idx_nxt_s = bit_idx_r;
        baud_nxt_s    = baud_r;
        div_act_nxt_s = div_act_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                baud_nxt_s = 16'd0;
                if (!empty_s) begin
                    pop_s         = 1'b1;
                    state_nxt_s   = ST_START;
                    shift_nxt_s   = fifo_mem_r[rd_ptr_r];
                    div_act_nxt_s = div_eff_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nxt_s   = ST_DATA;
                    bit_idx_nxt_s = 3'd0;
                    baud_nxt_s    = 16'd0;
                end else begin
                    baud_nxt_s = baud_r + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_nxt_s = {1'b0, shift_r[7:1]};
                    baud_nxt_s  = 16'd0;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s   = ST_STOP;
                        bit_idx_nxt_s = 3'd0;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_nxt_s = baud_r + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_nxt_s = 16'd0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!empty_s) begin
                        pop_s         = 1'b1;
                        state_nxt_s   = ST_START;
                        shift_nxt_s   = fifo_mem_r[rd_ptr_r];
                        div_act_nxt_s = div_eff_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    baud_nxt_s = baud_r + 16'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                baud_nxt_s  = 16'd0;
            end
        endcase
    end

    // Next FIFO occupancy.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= write_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Software-visible divisor and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r      <= DEFAULT_DIVISOR;
            overflow_r <= 1'b0;
        end else begin
            if (wr_div_lo_s) begin
                div_r[7:0] <= write_data;
            end
            if (wr_div_hi_s) begin
                div_r[15:8] <= write_data;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (wr_status_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Sequencer state and registered line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'h00;
            bit_idx_r <= 3'd0;
            baud_r    <= 16'd0;
            div_act_r <= 16'd1;
            tx_r      <= 1'b1;
            tx_idle_r <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            shift_r   <= shift_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            baud_r    <= baud_nxt_s;
            div_act_r <= div_act_nxt_s;
            tx_r      <= line_level(state_nxt_s, shift_nxt_s[0]);
            tx_idle_r <= (state_nxt_s == ST_IDLE) && (count_nxt_s == CNT_W'(0));
        end
    end

    assign tx      = tx_r;
    assign tx_idle = tx_idle_r;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a queue-based line model checked every cycle, plus
// directed frames with hand-derived bit patterns.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = BASE;
    logic [7:0]  write_data = 8'h00;
    logic        write_enable = 1'b0;
    logic [7:0]  read_data;
    logic        tx, tx_idle;

    int checks = 0;
    int errors = 0;
    logic tx_log[$];

    mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIVISOR(16'd4)) dut (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .write_enable(write_enable), .read_data(read_data), .tx(tx), .tx_idle(tx_idle)
    );

    always #5 clk = ~clk;

    // Reference model: queued bytes plus the future line waveform, one entry per clock.
    logic [7:0]  m_fifo[$];
    logic        m_wave[$];
    logic [15:0] m_div = 16'd4;
    logic        m_ovf = 1'b0;

    always @(posedge clk or negedge rst) begin : model
        int   old_n;
        int   d;
        logic do_pop;
        logic bv;
        logic [7:0] b;
        if (!rst) begin
            m_fifo.delete();
            m_wave.delete();
            m_div = 16'd4;
            m_ovf = 1'b0;
        end else begin
            if (m_wave.size() > 0) void'(m_wave.pop_front());
            old_n  = m_fifo.size();
            do_pop = (m_wave.size() == 0) && (old_n > 0);
            if (do_pop) begin
                b = m_fifo.pop_front();
                d = (m_div == 16'd0) ? 1 : int'(m_div);
                for (int i = 0; i < 10; i++) begin
                    bv = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
                    for (int k = 0; k < d; k++) m_wave.push_back(bv);
                end
            end
            if (write_enable && address[31:2] == BASE[31:2]) begin
                case (address[1:0])
                    2'd0: if (old_n < DEPTH || do_pop) m_fifo.push_back(write_data);
                          else m_ovf = 1'b1;
                    2'd1: m_ovf = 1'b0;
                    2'd2: m_div[7:0] = write_data;
                    default: m_div[15:8] = write_data;
                endcase
            end
        end
    end

    function automatic logic m_tx();
        return (m_wave.size() > 0) ? m_wave[0] : 1'b1;
    endfunction

    function automatic logic m_idle();
        return (m_wave.size() == 0) && (m_fifo.size() == 0);
    endfunction

    function automatic logic [7:0] m_read(input logic [31:0] a);
        int lvl;
        lvl = m_fifo.size();
        if (a[31:2] != BASE[31:2]) return 8'h00;
        case (a[1:0])
            2'd1: return {4'(lvl), m_ovf, (lvl == 0), (lvl == DEPTH), (m_wave.size() > 0)};
            2'd2: return m_div[7:0];
            2'd3: return m_div[15:8];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [19:0] frame_of(input logic [7:0] b);
        return {10'd0, 1'b1, b, 1'b0};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: compare against the model away from the edge, then advance.
    task automatic step();
        @(negedge clk);
        tx_log.push_back(tx);
        chk("tx", 16'(tx), 16'(m_tx()));
        chk("tx_idle", 16'(tx_idle), 16'(m_idle()));
        chk("read_data", 16'(read_data), 16'(m_read(address)));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        write_enable = 1'b0;
        repeat (n) step();
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] d);
        address      = BASE + 32'(off);
        write_data   = d;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] off, input logic [7:0] exp, input string nm);
        write_enable = 1'b0;
        address      = BASE + 32'(off);
        #1;
        chk(nm, 16'(read_data), 16'(exp));
    endtask

    task automatic check_bits(input int s, input logic [19:0] bits, input int nb,
                              input int d, input string nm);
        logic a;
        for (int i = 0; i < nb * d; i++) begin
            a = (s + i < tx_log.size()) ? tx_log[s+i] : 1'bx;
            chk(nm, 16'(a), 16'(bits[i/d]));
        end
    endtask

    initial begin
        int w;
        logic [31:0] a;

        // Reset and readback
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 16'(tx), 16'h0001);
        chk("rst_idle", 16'(tx_idle), 16'h0001);
        rst = 1'b1;
        #1;
        rd_chk(2'd0, 8'h00, "rd_txdata");
        rd_chk(2'd1, 8'h04, "rd_status");
        rd_chk(2'd2, 8'h04, "rd_div_lo");
        rd_chk(2'd3, 8'h00, "rd_div_hi");
        idle(2);
        wr(2'd3, 8'h01);
        rd_chk(2'd3, 8'h01, "rd_div_hi_w");
        wr(2'd3, 8'h00);

        // Single frame, div 4
        w = tx_log.size();
        wr(2'd0, 8'h41);
        idle(45);
        chk("pre_start", 16'(tx_log[w+1]), 16'h0001);
        check_bits(w + 2, 20'b0000000000_1010000010, 10, 4, "frame41");
        chk("idle_after41", 16'(tx_idle), 16'h0001);

        // Back-to-back, div 2
        wr(2'd2, 8'h02);
        w = tx_log.size();
        wr(2'd0, 8'h55);
        wr(2'd0, 8'hAA);
        rd_chk(2'd1, 8'h11, "status_lvl1");
        idle(45);
        check_bits(w + 2, 20'b1101010100_1010101010, 20, 2, "b2b");

        // Overflow, div 1000
        wr(2'd2, 8'hE8);
        wr(2'd3, 8'h03);
        w = tx_log.size();
        for (int i = 0; i < 10; i++) wr(2'd0, 8'h10 + 8'(i));
        rd_chk(2'd1, 8'h8B, "status_ovf");
        wr(2'd1, 8'h00);
        rd_chk(2'd1, 8'h83, "status_clr");
        wr(2'd2, 8'h01);
        wr(2'd3, 8'h00);
        idle(10120);
        check_bits(w + 2, frame_of(8'h10), 10, 1000, "ovf_f0");
        for (int i = 1; i < 9; i++)
            check_bits(w + 10002 + (i - 1) * 10, frame_of(8'h10 + 8'(i)), 10, 1, "ovf_fn");
        chk("ovf_dropped", 16'(tx_log[w+10082]), 16'h0001);
        chk("ovf_idle", 16'(tx_idle), 16'h0001);

        // Divisor 0 behaves as 1
        wr(2'd2, 8'h00);
        w = tx_log.size();
        wr(2'd0, 8'h0F);
        idle(15);
        check_bits(w + 2, frame_of(8'h0F), 10, 1, "div0");
        chk("div0_end", 16'(tx_log[w+12]), 16'h0001);

        // Divisor change mid-frame affects only the next frame
        wr(2'd2, 8'h04);
        w = tx_log.size();
        wr(2'd0, 8'h41);
        wr(2'd0, 8'h0F);
        idle(10);
        wr(2'd2, 8'h08);
        idle(130);
        check_bits(w + 2, frame_of(8'h41), 10, 4, "divchg_f1");
        check_bits(w + 42, frame_of(8'h0F), 10, 8, "divchg_f2");

        // Randomized traffic, small divisors
        for (int n = 0; n < 3000; n++) begin
            a = ($urandom_range(0, 9) < 7) ? BASE + 32'($urandom_range(0, 3)) : 32'($urandom);
            address      = a;
            write_enable = 1'($urandom_range(0, 1));
            write_data   = 8'($urandom);
            if (a[31:2] == BASE[31:2] && a[1:0] == 2'd2) write_data = 8'($urandom_range(0, 3));
            if (a[31:2] == BASE[31:2] && a[1:0] == 2'd3) write_data = 8'h00;
            step();
        end
        address = BASE + 32'd1;
        idle(300);

        // Reset during DATA bit 3
        wr(2'd2, 8'h04);
        wr(2'd3, 8'h00);
        w = tx_log.size();
        wr(2'd0, 8'h41);
        wr(2'd0, 8'h42);
        repeat (18) step();
        rst = 1'b0;
        #1;
        chk("midrst_tx", 16'(tx), 16'h0001);
        chk("midrst_idle", 16'(tx_idle), 16'h0001);
        rd_chk(2'd1, 8'h04, "midrst_status");
        idle(2);
        rst = 1'b1;
        w = tx_log.size();
        idle(60);
        for (int i = w; i < tx_log.size(); i++) chk("no_frame_after_rst", 16'(tx_log[i]), 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Byte-wide memory-mapped responder on the CPU's byte data bus, the same bus the memory controller drives towards RAM.
- Decodes a 4-byte address window.
- Stores written bytes in a small FIFO and serialises them as 8N1 UART frames on `tx`.
- Gives the CPU a store-to-console path; firmware polls STATUS with byte loads.

Parameters:
- BASE_ADDR, 32'h0000_1000, first byte address of the 4-byte register window; must be 4-byte aligned.
- FIFO_DEPTH, 8, transmit FIFO entries; power of two, 2..16.
- DEFAULT_DIVISOR, 16'd4, clocks per UART bit after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- address  in  32  byte address from the bus initiator.
- write_data  in  8  store byte.
- write_enable  in  1  store strobe; sampled on the rising clk edge.
- read_data  out  8  combinational load data.
- tx  out  1  UART serial output; idles high.
- tx_idle  out  1  high when the FSM is IDLE and the FIFO is empty.

Behaviour:
- Hit: `address[31:2] == BASE_ADDR[31:2]`. Offset `off = address[1:0]`.
- Non-hit: `read_data` = 8'h00; writes are ignored.
- Register map:
  - off 0 TXDATA: write pushes `write_data` into the FIFO; read returns 8'h00.
  - off 1 STATUS (read):
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[7:4] FIFO level, 0..FIFO_DEPTH, saturating at 15.
  - off 1 STATUS (write): any value clears overflow.
  - off 2 DIV_LO, off 3 DIV_HI: read/write bytes of the 16-bit divisor.
- Divisor value 0 is treated as 1. The divisor is latched into the active copy when a frame enters START; a change mid-frame affects the next frame only.
- Reset (rst low, asynchronous) forces:
  - tx=1, tx_idle=1, FSM=IDLE;
  - FIFO empty, pointers 0;
  - overflow=0, divisor=DEFAULT_DIVISOR;
  - bit counter and baud counter 0.
  - `read_data` follows the reset register contents (STATUS reads 8'h04).
  - Reset mid-frame truncates the frame; tx returns high immediately.
- FIFO: circular, with separate read/write pointers plus an occupancy count.
  - Push to a full FIFO with no pop in the same cycle: byte dropped, overflow set.
  - Simultaneous push and pop while full: push accepted, level unchanged, no overflow.
  - Simultaneous push and pop while empty is impossible: a pop requires non-empty at the edge.
- FSM states: IDLE, START, DATA, STOP. The baud counter counts 0..div-1; one bit time = div clocks.
  - IDLE: tx=1. If FIFO non-empty: pop head into the shift register, latch divisor, go to START (1 cycle after the push edge at the earliest).
  - START: tx=0 for one bit time, then DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. At the end of each bit time, shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for one bit time. At its end:
    - if FIFO non-empty, pop and go directly to START (no idle gap between frames);
    - else go to IDLE.
- Frame length is exactly 10×div clocks.
- Latency: store edge at cycle N → FIFO non-empty after N → pop edge N+1 → tx low from after edge N+1.
- Loads have no side effects. Byte loads of STATUS reflect state after the most recent edge.

Test Plan:
- Reset/readback:
  - Hold rst low, then release. Expect tx=1, tx_idle=1, and reads of offsets 0..3 = 00, 04, 04, 00.
  - Write DIV_HI=0x01, read off 3 → 0x01.
- Single frame, div=4: write 0x41 to BASE_ADDR.
  - tx low from 1 cycle after the store edge.
  - Bit sequence 0,1,0,0,0,0,0,1,0,1, each 4 clocks (40 clocks total).
  - tx_idle=1 afterwards.
- Back-to-back: write 0x55 then 0xAA on consecutive cycles with div=2.
  - Two frames, 20 clocks each, stop bit of frame 1 directly followed by start bit of frame 2.
  - STATUS level reads 0x1 after the first pop.
- Overflow, FIFO_DEPTH=8, div=1000:
  - Write 10 bytes in consecutive cycles. First pops at cycle 1, so 9 are accepted and 1 is dropped.
  - STATUS = 0x8B (level 8, overflow, full, busy).
  - Write STATUS → bit3 cleared.
  - Transmitted bytes are the first 9 in order.
- Divisor edge cases:
  - div=0: frame bits 1 clock each.
  - Change div 4→8 during frame 1: frame 1 stays 40 clocks, frame 2 is 80 clocks.
- Reset mid-frame: assert rst during DATA bit 3 → tx=1 asynchronously, FIFO empty, no further frame after release.
